// File: rtl/branch_sequencer_if.sv
// Bus bundle for the conditional-branch sequencer: the request side (start, ir,
// conditionMet) plus every datapath strobe, status flag and counter it produces.
interface branch_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic        conditionMet;
  logic        Gra;
  logic        Rout;
  logic        CONin;
  logic        PCout;
  logic        Yin;
  logic        Cout;
  logic        Zin;
  logic        Zlowout;
  logic        PCin;
  logic [4:0]  alu_op;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;
  logic [15:0] branch_count;
  logic [15:0] taken_count;
  logic [31:0] ir_hold;

  // Requester / control-unit side
  modport master (
    output start, ir, conditionMet,
    input  Gra, Rout, CONin, PCout, Yin, Cout, Zin, Zlowout, PCin,
    input  alu_op, busy, done, taken, illegal,
    input  branch_count, taken_count, ir_hold
  );

  // Sequencer side
  modport slave (
    input  start, ir, conditionMet,
    output Gra, Rout, CONin, PCout, Yin, Cout, Zin, Zlowout, PCin,
    output alu_op, busy, done, taken, illegal,
    output branch_count, taken_count, ir_hold
  );
endinterface

// File: rtl/branch_sequencer.sv
// Conditional-branch control sequencer: walks T3..T6 issuing datapath strobes,
// latches the branch condition in T5, conditionally loads PC in T6 and keeps
// executed/taken branch statistics. Every output is decoded from registers only.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10010,
  parameter logic [4:0] ALU_ADD   = 5'b00011
) (
  input  logic                clock,
  input  logic                clear,
  branch_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] ir_reg;
  logic        cond_q;
  logic        illegal_reg;
  logic [15:0] branch_count_q;
  logic [15:0] taken_count_q;

  logic is_branch;
  logic accept;
  logic reject;

  // Requests are only looked at while idle; anything arriving mid-sequence is dropped.
  assign is_branch = (bus.ir[31:27] == BR_OPCODE);
  assign accept    = (state_reg == IDLE) && bus.start && is_branch;
  assign reject    = (state_reg == IDLE) && bus.start && !is_branch;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Instruction capture, condition latch, illegal pulse and statistics counters
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ir_reg         <= 32'h0;
      cond_q         <= 1'b0;
      illegal_reg    <= 1'b0;
      branch_count_q <= 16'h0;
      taken_count_q  <= 16'h0;
    end else begin
      illegal_reg <= reject;
      if (accept) begin
        ir_reg <= bus.ir;
      end
      if (state_reg == T5) begin
        cond_q <= bus.conditionMet;
      end
      // Counters move on the T6->DONE edge so an aborted sequence never counts.
      if (state_reg == T6) begin
        branch_count_q <= branch_count_q + 16'd1;
        taken_count_q  <= taken_count_q + {15'd0, cond_q};
      end
    end
  end

  // Next-state and state-decoded strobes
  always_comb begin
    state_next  = state_reg;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CONin   = 1'b0;
    bus.PCout   = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.alu_op  = 5'b00000;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    bus.taken   = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.busy = 1'b0;
        if (accept) begin
          state_next = T3;
        end
      end
      T3: begin
        bus.Gra    = 1'b1;
        bus.Rout   = 1'b1;
        bus.CONin  = 1'b1;
        state_next = T4;
      end
      T4: begin
        bus.PCout  = 1'b1;
        bus.Yin    = 1'b1;
        state_next = T5;
      end
      T5: begin
        bus.Cout   = 1'b1;
        bus.Zin    = 1'b1;
        bus.alu_op = ALU_ADD;
        state_next = T6;
      end
      T6: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = cond_q;
        state_next  = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        bus.taken  = cond_q;
        state_next = IDLE;
      end
      default: begin
        bus.busy   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.illegal      = illegal_reg;
  assign bus.branch_count = branch_count_q;
  assign bus.taken_count  = taken_count_q;
  assign bus.ir_hold      = ir_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a per-cycle vector table for the main
// flows, then hand-written sequences for async clear and counter wrap.
module tb_branch_sequencer;

  logic clock;
  logic clear;

  branch_sequencer_if bus ();

  branch_sequencer #(
    .BR_OPCODE(5'b10010),
    .ALU_ADD  (5'b00011)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Strobe bit order: Gra Rout CONin PCout Yin Cout Zin Zlowout PCin
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_T3   = 9'b111000000;
  localparam logic [8:0] S_T4   = 9'b000110000;
  localparam logic [8:0] S_T5   = 9'b000001100;
  localparam logic [8:0] S_T6N  = 9'b000000010;
  localparam logic [8:0] S_T6T  = 9'b000000011;

  // Status bit order: busy done taken illegal
  localparam logic [3:0] ST_IDLE = 4'b0000;
  localparam logic [3:0] ST_BUSY = 4'b1000;
  localparam logic [3:0] ST_DNT  = 4'b1100;
  localparam logic [3:0] ST_DT   = 4'b1110;
  localparam logic [3:0] ST_ILL  = 4'b0001;

  localparam logic [31:0] IR_BRZR = 32'h9000_0005;
  localparam logic [31:0] IR_BRNZ = 32'h9088_0010;
  localparam logic [31:0] IR_BAD  = 32'h1000_0000;

  typedef struct {
    logic        start;
    logic [31:0] ir;
    logic        cond;
    logic [8:0]  strobes;
    logic [4:0]  alu_op;
    logic [3:0]  status;
    logic [15:0] bcnt;
    logic [15:0] tcnt;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [8:0] get_strobes();
    return {bus.Gra, bus.Rout, bus.CONin, bus.PCout, bus.Yin,
            bus.Cout, bus.Zin, bus.Zlowout, bus.PCin};
  endfunction

  function automatic logic [3:0] get_status();
    return {bus.busy, bus.done, bus.taken, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] i, input logic c);
    bus.start        = s;
    bus.ir           = i;
    bus.conditionMet = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {23'd0, get_strobes()}, 32'd0);
    chk({tag, "_alu"},     {27'd0, bus.alu_op},    32'd0);
    chk({tag, "_status"},  {28'd0, get_status()},  32'd0);
    chk({tag, "_bcnt"},    {16'd0, bus.branch_count}, 32'd0);
    chk({tag, "_tcnt"},    {16'd0, bus.taken_count},  32'd0);
  endtask

  // Runs one full branch from IDLE and checks strobes in each cycle.
  task automatic run_branch(input string tag, input logic [31:0] i, input logic c,
                            input logic [15:0] exp_b, input logic [15:0] exp_t);
    logic [8:0] exp_s;
    drive(1'b1, i, c);
    step();
    chk({tag, "_t3"}, {23'd0, get_strobes()}, {23'd0, S_T3});
    drive(1'b0, i, c);
    step();
    chk({tag, "_t4"}, {23'd0, get_strobes()}, {23'd0, S_T4});
    step();
    chk({tag, "_t5"}, {23'd0, get_strobes()}, {23'd0, S_T5});
    step();
    exp_s = c ? S_T6T : S_T6N;
    chk({tag, "_t6"}, {23'd0, get_strobes()}, {23'd0, exp_s});
    step();
    chk({tag, "_done"}, {28'd0, get_status()}, {28'd0, (c ? ST_DT : ST_DNT)});
    chk({tag, "_bcnt"}, {16'd0, bus.branch_count}, {16'd0, exp_b});
    chk({tag, "_tcnt"}, {16'd0, bus.taken_count},  {16'd0, exp_t});
    step();
    chk({tag, "_idle"}, {28'd0, get_status()}, {28'd0, ST_IDLE});
    $display("branch %s ir=%h cond=%0b counts=%0d/%0d", tag, i, c,
             bus.branch_count, bus.taken_count);
  endtask

  initial begin
    // brzr taken
    vecs[0]  = '{1'b1, IR_BRZR, 1'b0, S_T3,   5'd0, ST_BUSY, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, IR_BRZR, 1'b1, S_T4,   5'd0, ST_BUSY, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, IR_BRZR, 1'b1, S_T5,   5'd3, ST_BUSY, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, IR_BRZR, 1'b1, S_T6T,  5'd0, ST_BUSY, 16'd0, 16'd0};
    vecs[4]  = '{1'b0, IR_BRZR, 1'b0, S_NONE, 5'd0, ST_DT,   16'd1, 16'd1};
    vecs[5]  = '{1'b0, IR_BRZR, 1'b0, S_NONE, 5'd0, ST_IDLE, 16'd1, 16'd1};
    // illegal opcode
    vecs[6]  = '{1'b1, IR_BAD,  1'b0, S_NONE, 5'd0, ST_ILL,  16'd1, 16'd1};
    vecs[7]  = '{1'b0, IR_BAD,  1'b0, S_NONE, 5'd0, ST_IDLE, 16'd1, 16'd1};
    // brnz not taken
    vecs[8]  = '{1'b1, IR_BRNZ, 1'b0, S_T3,   5'd0, ST_BUSY, 16'd1, 16'd1};
    vecs[9]  = '{1'b0, IR_BRNZ, 1'b0, S_T4,   5'd0, ST_BUSY, 16'd1, 16'd1};
    vecs[10] = '{1'b0, IR_BRNZ, 1'b0, S_T5,   5'd3, ST_BUSY, 16'd1, 16'd1};
    vecs[11] = '{1'b0, IR_BRNZ, 1'b0, S_T6N,  5'd0, ST_BUSY, 16'd1, 16'd1};
    vecs[12] = '{1'b0, IR_BRNZ, 1'b0, S_NONE, 5'd0, ST_DNT,  16'd2, 16'd1};
    vecs[13] = '{1'b0, IR_BRNZ, 1'b0, S_NONE, 5'd0, ST_IDLE, 16'd2, 16'd1};
    // start during T4 (legal IR) and during T5 (illegal IR) are both ignored
    vecs[14] = '{1'b1, IR_BRZR, 1'b1, S_T3,   5'd0, ST_BUSY, 16'd2, 16'd1};
    vecs[15] = '{1'b0, IR_BRZR, 1'b1, S_T4,   5'd0, ST_BUSY, 16'd2, 16'd1};
    vecs[16] = '{1'b1, IR_BRNZ, 1'b1, S_T5,   5'd3, ST_BUSY, 16'd2, 16'd1};
    vecs[17] = '{1'b1, IR_BAD,  1'b1, S_T6T,  5'd0, ST_BUSY, 16'd2, 16'd1};
    vecs[18] = '{1'b0, IR_BRZR, 1'b0, S_NONE, 5'd0, ST_DT,   16'd3, 16'd2};
    vecs[19] = '{1'b0, IR_BRZR, 1'b0, S_NONE, 5'd0, ST_IDLE, 16'd3, 16'd2};
    vecs[20] = '{1'b0, IR_BRZR, 1'b0, S_NONE, 5'd0, ST_IDLE, 16'd3, 16'd2};

    // Reset state
    clear = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    clear = 1'b1;
    #1;

    // Table-driven main flows; each vector is checked right after the edge that consumes it
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].start, vecs[i].ir, vecs[i].cond);
      step();
      $display("vec %0d start=%0b ir=%h cond=%0b -> strobes=%b alu=%h status=%b counts=%0d/%0d",
               i, vecs[i].start, vecs[i].ir, vecs[i].cond, get_strobes(), bus.alu_op,
               get_status(), bus.branch_count, bus.taken_count);
      chk($sformatf("vec%0d_strobes", i), {23'd0, get_strobes()},    {23'd0, vecs[i].strobes});
      chk($sformatf("vec%0d_alu", i),     {27'd0, bus.alu_op},       {27'd0, vecs[i].alu_op});
      chk($sformatf("vec%0d_status", i),  {28'd0, get_status()},     {28'd0, vecs[i].status});
      chk($sformatf("vec%0d_bcnt", i),    {16'd0, bus.branch_count}, {16'd0, vecs[i].bcnt});
      chk($sformatf("vec%0d_tcnt", i),    {16'd0, bus.taken_count},  {16'd0, vecs[i].tcnt});
    end
    // The ignored mid-sequence start must not have replaced the captured IR
    chk("ir_hold_kept", bus.ir_hold, IR_BRZR);

    // Clear pulled low in T5: immediate async zeroing, no PCin, no done
    drive(1'b1, IR_BRZR, 1'b1);
    step();
    drive(1'b0, IR_BRZR, 1'b1);
    step();
    step();
    chk("pre_clear_t5", {23'd0, get_strobes()}, {23'd0, S_T5});
    #2;
    clear = 1'b0;
    #1;
    chk_all_zero("clear_async");
    $display("clear asserted in T5 at %0t", $time);
    step();
    chk_all_zero("clear_held");
    @(negedge clock);
    clear = 1'b1;
    #1;
    chk_all_zero("clear_release");

    // Fresh start right after clear completes normally
    run_branch("after_clear", IR_BRZR, 1'b1, 16'd1, 16'd1);

    // C2 above 3 is sequenced normally; flip-flop reports 0 so PCin stays low
    run_branch("c2_high", 32'h90F8_0000, 1'b0, 16'd2, 16'd1);

    // Counter wrap: preload both counters to all-ones, then one taken branch
    @(negedge clock);
    dut.branch_count_q = 16'hFFFF;
    dut.taken_count_q  = 16'hFFFF;
    #1;
    chk("preload_bcnt", {16'd0, bus.branch_count}, 32'h0000_FFFF);
    run_branch("wrap", IR_BRZR, 1'b1, 16'h0000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
